unit_prop_scheduler: RTL

Sequencer for one boolean-constraint-propagation (BCP) sweep. It walks the clause table from index 0 to `num_clauses-1`, reads each clause plus its current literal status, and feeds the combinational `unit_clause_evaluator`. It forwards every implied assignment over a valid/ready handshake and aborts the sweep on the first conflicting clause. It sits between the solver top-level controller (start/done) and the clause table / implication queue.

---
 rtl/bcp_pkg.sv | 25 ++
 rtl/unit_clause_evaluator.sv | 35 +++
 rtl/unit_prop_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bcp_pkg.sv
// Shared types for the BCP sweep sequencer and the unit-clause evaluator.
package bcp_pkg;

  // Clause geometry, normally supplied by the shared system definitions.
  localparam int VAR_PER_CLAUSE = 8;
  localparam int MAX_VARS_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_PUSH,
    ST_DONE
  } bcp_state_t;

  // One clause-table read: literal mask, polarity, variables and live status.
  typedef struct packed {
    logic [VAR_PER_CLAUSE-1:0]                    mask;
    logic [VAR_PER_CLAUSE-1:0]                    pole;
    logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] variable;
    logic [VAR_PER_CLAUSE-1:0]                    unassign;
    logic [VAR_PER_CLAUSE-1:0]                    lit_true;
  } clause_rd_t;

endpackage

// File: rtl/unit_clause_evaluator.sv
// Combinational unit-clause detector: exactly one live unassigned literal.
module unit_clause_evaluator
  import bcp_pkg::*;
(
  input  logic [VAR_PER_CLAUSE-1:0]                    unassigned,
  input  logic [VAR_PER_CLAUSE-1:0]                    mask,
  input  logic [VAR_PER_CLAUSE-1:0]                    pole,
  input  logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] variable,
  output logic                                         is_unit_clause,
  output logic [MAX_VARS_BITS-1:0]                     unit_var,
  output logic                                         unit_val
);

  localparam int CNT_W = $clog2(VAR_PER_CLAUSE + 1);

  logic [VAR_PER_CLAUSE-1:0] live;
  logic [CNT_W-1:0]          cnt;

  // Count live unassigned literals and capture the (single) implied literal.
  always_comb begin
    live     = unassigned & mask;
    cnt      = '0;
    unit_var = '0;
    unit_val = 1'b0;
    for (int unsigned i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (live[i]) begin
        cnt      = cnt + CNT_W'(1);
        unit_var = variable[i];
        unit_val = ~pole[i];
      end
    end
    is_unit_clause = (cnt == CNT_W'(1));
  end

endmodule

// File: rtl/unit_prop_scheduler.sv
// Sequencer for one BCP sweep over the clause table.
module unit_prop_scheduler
  import bcp_pkg::*;
#(
  parameter int CLAUSE_IDX_W = 10
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic                                         start,
  input  logic [CLAUSE_IDX_W:0]                        num_clauses,
  output logic                                         rd_en,
  output logic [CLAUSE_IDX_W-1:0]                      rd_addr,
  input  logic [VAR_PER_CLAUSE-1:0]                    rd_mask,
  input  logic [VAR_PER_CLAUSE-1:0]                    rd_pole,
  input  logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] rd_variable,
  input  logic [VAR_PER_CLAUSE-1:0]                    rd_unassign,
  input  logic [VAR_PER_CLAUSE-1:0]                    rd_lit_true,
  output logic                                         imp_valid,
  input  logic                                         imp_ready,
  output logic [MAX_VARS_BITS-1:0]                     imp_var,
  output logic                                         imp_val,
  output logic [CLAUSE_IDX_W-1:0]                      imp_clause,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         conflict,
  output logic [CLAUSE_IDX_W-1:0]                      conflict_clause,
  output logic [CLAUSE_IDX_W:0]                        imp_count
);

  bcp_state_t               state, state_next;
  logic [CLAUSE_IDX_W-1:0]  idx;
  logic [CLAUSE_IDX_W:0]    n_lat;
  clause_rd_t               rd;
  logic                     eval_sat, eval_unit, eval_confl;
  logic [MAX_VARS_BITS-1:0] u_var;
  logic                     u_val;
  logic                     last, adv;

  assign rd = '{rd_mask, rd_pole, rd_variable, rd_unassign, rd_lit_true};

  unit_clause_evaluator u_eval (
    .unassigned     (rd.unassign & rd.mask),
    .mask           (rd.mask),
    .pole           (rd.pole),
    .variable       (rd.variable),
    .is_unit_clause (eval_unit),
    .unit_var       (u_var),
    .unit_val       (u_val)
  );

  assign eval_sat   = |(rd.lit_true & rd.mask);
  assign eval_confl = !eval_sat && ((rd.unassign & rd.mask) == '0);
  assign last       = ({1'b0, idx} == (n_lat - (CLAUSE_IDX_W+1)'(1)));

  assign rd_en     = (state == ST_READ);
  assign rd_addr   = idx;
  assign imp_valid = (state == ST_PUSH);
  assign busy      = (state == ST_READ) || (state == ST_EVAL) || (state == ST_PUSH);
  assign done      = (state == ST_DONE);

  // Next-state selection; adv marks finishing the current clause.
  always_comb begin
    state_next = state;
    adv        = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = (num_clauses == '0) ? ST_DONE : ST_READ;
      ST_READ: state_next = ST_EVAL;
      ST_EVAL: begin
        if (eval_confl)                  state_next = ST_DONE;
        else if (!eval_sat && eval_unit) state_next = ST_PUSH;
        else                             adv = 1'b1;
      end
      ST_PUSH: if (imp_ready) adv = 1'b1;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (adv) state_next = last ? ST_DONE : ST_READ;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Index, implication payload and sweep status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx             <= '0;
      n_lat           <= '0;
      imp_var         <= '0;
      imp_val         <= 1'b0;
      imp_clause      <= '0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      imp_count       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          n_lat           <= num_clauses;
          idx             <= '0;
          imp_count       <= '0;
          conflict        <= 1'b0;
          conflict_clause <= '0;
        end
        ST_EVAL: begin
          if (eval_confl) begin
            conflict        <= 1'b1;
            conflict_clause <= idx;
          end else if (!eval_sat && eval_unit) begin
            imp_var    <= u_var;
            imp_val    <= u_val;
            imp_clause <= idx;
          end
        end
        ST_PUSH: if (imp_ready && (imp_count != '1)) imp_count <= imp_count + (CLAUSE_IDX_W+1)'(1);
        default: ;
      endcase
      if (adv && !last) idx <= idx + CLAUSE_IDX_W'(1);
    end
  end

endmodule
